// File: rtl/tone_sequencer.sv
// Melody player: walks a fixed 16-entry note ROM and drives the half-period limit
// of a downstream programmable clock divider, one note per (dur+1) time units.
module tone_sequencer #(
   parameter int unsigned CLK_HZ      = 100_000_000,
   parameter int unsigned UNIT_CYCLES = 25_000_000,
   parameter int unsigned SONG_LEN    = 16
) (
   input  logic        CLOCK,
   input  logic        RESETN,
   input  logic        start,
   input  logic        stop,
   input  logic        loop,
   output logic [31:0] m,
   output logic        tone_en,
   output logic        busy,
   output logic        done,
   output logic [3:0]  note_idx
);

   localparam int CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UNIT_CYCLES - 1);
   localparam logic [3:0]       IDX_LAST = 4'(SONG_LEN - 1);

   function automatic logic [31:0] calc_m(input int unsigned hz);
      return 32'((64'(CLK_HZ) / (64'd2 * 64'(hz))) - 64'd1);
   endfunction

   // Divider limits, indexed by note code; code 0 (rest) and unused codes give 0.
   localparam logic [31:0] M_TAB [0:15] = '{
      32'd0, calc_m(262), calc_m(294), calc_m(330), calc_m(349),
      calc_m(392), calc_m(440), calc_m(494), calc_m(523),
      32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0
   };

   // Entry = {code, dur}: rising scale, falling back to C4, then a two-unit rest.
   function automatic logic [5:0] rom_entry(input logic [3:0] idx);
      if (idx <= 4'd7)
         return {idx + 4'd1, 2'd0};
      else if (idx <= 4'd14)
         return {4'd15 - idx, 2'd0};
      else
         return {4'd0, 2'd1};
   endfunction

   typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] unit_cnt;
   logic [2:0]       dur_left;
   logic [5:0]       rom;
   logic [3:0]       code;
   logic [1:0]       dur;
   logic             wrap, last_unit, last_note;
   logic             clr_out, fin;

   assign rom  = rom_entry(note_idx);
   assign code = rom[5:2];
   assign dur  = rom[1:0];

   always_comb begin
      state_nxt = state;
      clr_out   = 1'b0;
      fin       = 1'b0;
      busy      = (state != IDLE);
      wrap      = (unit_cnt == CNT_LAST);
      last_unit = wrap && (dur_left == 3'd1);
      last_note = (note_idx == IDX_LAST);
      case (state)
         IDLE: if (!stop && start) state_nxt = LOAD;
         LOAD: begin
            if (stop) begin
               state_nxt = IDLE;
               clr_out   = 1'b1;
            end else begin
               state_nxt = PLAY;
            end
         end
         PLAY: begin
            if (stop) begin
               state_nxt = IDLE;
               clr_out   = 1'b1;
            end else if (last_unit) begin
               if (!last_note || loop) begin
                  state_nxt = LOAD;
               end else begin
                  state_nxt = IDLE;
                  clr_out   = 1'b1;
                  fin       = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            clr_out   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN) state <= IDLE;
      else         state <= state_nxt;
   end

   // m/tone_en only move at the end of LOAD or on entry to IDLE, so LOAD holds the old tone.
   always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN) begin
         m        <= 32'd0;
         tone_en  <= 1'b0;
         done     <= 1'b0;
         note_idx <= 4'd0;
         unit_cnt <= '0;
         dur_left <= 3'd1;
      end else begin
         done <= fin;
         if (clr_out) begin
            m       <= 32'd0;
            tone_en <= 1'b0;
         end else if (state == LOAD) begin
            m       <= M_TAB[code];
            tone_en <= (code != 4'd0);
         end
         case (state)
            IDLE: if (!stop && start) note_idx <= 4'd0;
            LOAD: begin
               dur_left <= 3'(dur) + 3'd1;
               unit_cnt <= '0;
            end
            PLAY: begin
               unit_cnt <= wrap ? '0 : unit_cnt + CNT_W'(1);
               if (wrap && dur_left != 3'd1) dur_left <= dur_left - 3'd1;
               if (state_nxt == LOAD) note_idx <= last_note ? 4'd0 : note_idx + 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboarded bench for tone_sequencer: a timeline model of the melody feeds an
// expected-output queue that a separate monitor compares against the DUT every cycle.
module tb_tone_sequencer;

  localparam int UNIT = 4;

  typedef struct packed {
    logic [31:0] m;
    logic        te;
    logic        busy;
    logic        done;
    logic [3:0]  idx;
  } rec_t;

  logic        CLOCK = 1'b0;
  logic        RESETN = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [31:0] m;
  logic        tone_en, busy, done;
  logic [3:0]  note_idx;

  rec_t        exp_q[$];
  rec_t        tl[$];
  bit          tl_loop[$];
  logic [3:0]  cur_idx = 4'd0;
  bit          stim_end = 1'b0;
  int          checks = 0;
  int          failures = 0;

  int song_code [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 1, 0};
  int song_dur  [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  tone_sequencer #(
    .CLK_HZ(100_000_000),
    .UNIT_CYCLES(UNIT),
    .SONG_LEN(16)
  ) dut (
    .CLOCK(CLOCK),
    .RESETN(RESETN),
    .start(start),
    .stop(stop),
    .loop(loop),
    .m(m),
    .tone_en(tone_en),
    .busy(busy),
    .done(done),
    .note_idx(note_idx)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic rec_t mk(input logic [31:0] mm, input logic te, input logic b,
                              input logic d, input logic [3:0] ix);
    rec_t r;
    r.m = mm; r.te = te; r.busy = b; r.done = d; r.idx = ix;
    return r;
  endfunction

  // Half-period limit straight from the note frequency: floor(Fclk / 2f) - 1.
  function automatic logic [31:0] mval(input int code);
    int f [9] = '{0, 262, 294, 330, 349, 392, 440, 494, 523};
    if (code == 0) return 32'd0;
    return 32'(100_000_000 / (2 * f[code]) - 1);
  endfunction

  task automatic step(input bit st, input bit sp, input bit lp, input bit rn, input rec_t e);
    @(negedge CLOCK);
    start  = st;
    stop   = sp;
    loop   = lp;
    RESETN = rn;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit both);
    for (int k = 0; k < n; k++)
      step(both, both, 1'($urandom_range(0, 1)), 1'b1, mk(32'd0, 1'b0, 1'b0, 1'b0, cur_idx));
  endtask

  // One playback: expand the melody into its cycle-by-cycle output timeline, then drive it.
  task automatic play(input int passes, input int stop_at, input bit jitter, input int rst_at);
    logic [31:0] pm, cm;
    logic        pte, cte;
    bit          st;
    tl.delete();
    tl_loop.delete();
    pm = 32'd0;
    pte = 1'b0;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < 16; i++) begin
        tl.push_back(mk(pm, pte, 1'b1, 1'b0, 4'(i)));
        tl_loop.push_back((i == 0 && p > 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        cm  = mval(song_code[i]);
        cte = (song_code[i] != 0);
        for (int k = 0; k < (song_dur[i] + 1) * UNIT; k++) begin
          tl.push_back(mk(cm, cte, 1'b1, 1'b0, 4'(i)));
          tl_loop.push_back(1'($urandom_range(0, 1)));
        end
        pm  = cm;
        pte = cte;
      end
    end
    tl.push_back(mk(32'd0, 1'b0, 1'b0, 1'b1, 4'd15));
    tl_loop.push_back(1'b0);
    for (int s = 0; s < tl.size(); s++) begin
      st = (s == 0) ? 1'b1 : (jitter && $urandom_range(0, 3) == 0);
      if (s == rst_at) begin
        @(posedge CLOCK);
        #3;
        exp_q.push_back(mk(32'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        RESETN = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, mk(32'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        step(1'b0, 1'b0, 1'b0, 1'b0, mk(32'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        step(1'b0, 1'b0, 1'b0, 1'b1, mk(32'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        cur_idx = 4'd0;
        return;
      end
      if (s == stop_at) begin
        step(st, 1'b1, tl_loop[s], 1'b1, mk(32'd0, 1'b0, 1'b0, 1'b0, tl[s-1].idx));
        cur_idx = tl[s-1].idx;
        return;
      end
      step(st, 1'b0, tl_loop[s], 1'b1, tl[s]);
    end
    cur_idx = 4'd15;
  endtask

  initial begin : stimulus
    int passes, len, stop_at;
    #1 RESETN = 1'b0;
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b0, 1'b0, 1'b0, mk(32'd0, 1'b0, 1'b0, 1'b0, 4'd0));
    idle(20, 1'b0);
    play(1, -1, 1'b0, -1);
    idle(3, 1'b0);
    play(2, -1, 1'b0, -1);
    idle(2, 1'b0);
    idle(3, 1'b1);
    play(1, 27, 1'b0, -1);
    idle(2, 1'b0);
    play(1, -1, 1'b1, -1);
    play(1, -1, 1'b0, 40);
    idle(2, 1'b0);
    play(1, -1, 1'b0, -1);
    for (int it = 0; it < 6; it++) begin
      passes  = $urandom_range(1, 2);
      len     = passes * 84 + 1;
      stop_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, len - 1) : -1;
      idle($urandom_range(0, 3), 1'b0);
      play(passes, stop_at, 1'($urandom_range(0, 1)), -1);
    end
    idle(2, 1'b0);
    @(negedge CLOCK);
    stim_end = 1'b1;
  end

  initial begin : monitor
    rec_t e, act;
    int   n;
    n = 0;
    while (!stim_end) begin
      @(posedge CLOCK or negedge RESETN);
      #1;
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = mk(m, tone_en, busy, done, note_idx);
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL out_cycle%0d got m=%0d te=%0b busy=%0b done=%0b idx=%0d want m=%0d te=%0b busy=%0b done=%0b idx=%0d",
                   n, act.m, act.te, act.busy, act.done, act.idx,
                   e.m, e.te, e.busy, e.done, e.idx);
        end
        n++;
      end
    end
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    if (checks < 100) begin
      failures++;
      $display("FAIL check_count got %0d want >= 100", checks);
    end
    if (busy !== 1'b0 || done !== 1'b0 || tone_en !== 1'b0 || m !== 32'd0) begin
      failures++;
      $display("FAIL end_state got busy=%0b done=%0b te=%0b m=%0d want all 0",
               busy, done, tone_en, m);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog time limit reached got running want finished");
    $fatal(1);
  end

endmodule
